// File: rtl/screen_rotate_multi_pkg.sv
// Shared orientation codes, read-side phases and output timing widths for the screen rotator.
package screen_rotate_multi_pkg;

    typedef enum logic [1:0] {
        ROT_NONE = 2'd0,
        ROT_CW   = 2'd1,
        ROT_180  = 2'd2,
        ROT_CCW  = 2'd3
    } rot_t;

    typedef enum logic [1:0] {
        PH_VBLANK = 2'd0,
        PH_TOP    = 2'd1,
        PH_ACTIVE = 2'd2,
        PH_BOTTOM = 2'd3
    } rd_phase_t;

    localparam int HSYNC_W     = 2;
    localparam int HTAIL       = 10;  // hsync plus back porch after the front porch
    localparam int VSYNC_START = 10;
    localparam int VSYNC_W     = 2;

    // CW and CCW are the odd codes; both swap output width and height.
    function automatic logic is_rotated(input logic [1:0] mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/screen_rotate_multi_addr_gen.sv
// Write-address table: frame start, per-pixel step and per-line step for a mode and buffer half.
module screen_rotate_multi_addr_gen
    import screen_rotate_multi_pkg::*;
#(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int AW     = 18
) (
    input  logic [1:0]    mode,
    input  logic          buf_sel,
    output logic [AW-1:0] start,
    output logic [AW-1:0] pstep,
    output logic [AW-1:0] rstep
);

    localparam int S = WIDTH * HEIGHT;

    logic [AW-1:0] base;

    // Negative steps are two's complement and rely on wrap modulo 2^AW.
    always_comb begin
        base  = buf_sel ? AW'(S) : '0;
        start = base;
        pstep = AW'(1);
        rstep = AW'(WIDTH);
        case (mode)
            ROT_CW: begin
                start = base + AW'(HEIGHT - 1);
                pstep = AW'(HEIGHT);
                rstep = '1;
            end
            ROT_180: begin
                start = base + AW'(S - 1);
                pstep = '1;
                rstep = AW'(0) - AW'(WIDTH);
            end
            ROT_CCW: begin
                start = base + AW'(S - HEIGHT);
                pstep = AW'(0) - AW'(HEIGHT);
                rstep = AW'(1);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/screen_rotate_multi.sv
// Double-buffered orientation stage: writes native frames in rotated order into one half,
// streams the other half linearly with scaler-only output timing.
module screen_rotate_multi
    import screen_rotate_multi_pkg::*;
#(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int DEPTH  = 8,
    parameter int MARGIN = 8,
    parameter int HFP    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic [DEPTH-1:0] video_in,
    input  logic             hblank,
    input  logic             vblank,
    input  logic [1:0]       rot,
    input  logic             ce_out,
    output logic [DEPTH-1:0] video_out,
    output logic             hsync,
    output logic             vsync,
    output logic             hblank_out,
    output logic             vblank_out,
    output logic [1:0]       mode_out,
    output rd_phase_t        rd_phase
);

    localparam int S    = WIDTH * HEIGHT;
    localparam int AW   = $clog2(2 * S);
    localparam int MAXD = (WIDTH > HEIGHT) ? WIDTH : HEIGHT;
    localparam int XW   = $clog2(MAXD + HFP + HTAIL + 1);
    localparam int YW   = $clog2(MAXD + 2 * MARGIN + VSYNC_START + VSYNC_W + 1);
    localparam int WXW  = $clog2(WIDTH + 1);
    localparam int WYW  = $clog2(HEIGHT + 1);

    // ---------------- write side ----------------
    logic             hb_d, vb_d, wr_en, wbuf;
    logic [1:0]       bmode [2];
    logic [AW-1:0]    waddr, wrow, pstep, rstep;
    logic [AW-1:0]    g_start, g_pstep, g_rstep;
    logic [WXW-1:0]   wx;
    logic [WYW-1:0]   wy;
    logic             vb_rise, hb_rise, wr;

    assign vb_rise = ce & vblank & ~vb_d;
    assign hb_rise = ce & hblank & ~hb_d & ~vblank;
    assign wr      = ce & ~reset & wr_en & ~hblank & ~vblank
                   & (wx < WXW'(WIDTH)) & (wy < WYW'(HEIGHT));

    screen_rotate_multi_addr_gen #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .AW(AW)) u_addr_gen (
        .mode    (rot),
        .buf_sel (~wbuf),
        .start   (g_start),
        .pstep   (g_pstep),
        .rstep   (g_rstep)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            hb_d     <= 1'b0;
            vb_d     <= 1'b0;
            wr_en    <= 1'b0;
            wbuf     <= 1'b0;
            bmode[0] <= 2'd0;
            bmode[1] <= 2'd0;
            waddr    <= '0;
            wrow     <= '0;
            pstep    <= '0;
            rstep    <= '0;
            wx       <= '0;
            wy       <= '0;
        end else begin
            if (ce) begin
                hb_d <= hblank;
                vb_d <= vblank;
            end
            if (vb_rise) begin
                wr_en        <= 1'b1;
                wbuf         <= ~wbuf;
                bmode[!wbuf] <= rot;
                waddr        <= g_start;
                wrow         <= g_start;
                pstep        <= g_pstep;
                rstep        <= g_rstep;
                wx           <= '0;
                wy           <= '0;
            end else if (hb_rise) begin
                wx    <= '0;
                wrow  <= wrow + rstep;
                waddr <= wrow + rstep;
                if (wy < WYW'(HEIGHT)) wy <= wy + WYW'(1);
            end else if (wr) begin
                wx    <= wx + WXW'(1);
                waddr <= waddr + pstep;
            end
        end
    end

    // ---------------- frame store ----------------
    logic [DEPTH-1:0] ram [2 * S];
    logic [DEPTH-1:0] s1_data;
    logic [AW-1:0]    raddr;

    always_ff @(posedge clk) begin
        if (wr) ram[waddr] <= video_in;
        if (ce_out) s1_data <= ram[raddr];
    end

    // ---------------- read side ----------------
    logic          rseen;
    logic [1:0]    rmode;
    logic [XW-1:0] xo, ow;
    logic [YW-1:0] yo, oh;
    logic [YW-1:0] vis_lines;
    logic          line_last, act_row, act_pix, hb_c, hs_c, vb_c, vs_c;
    logic          s1_act, s1_hb, s1_vb, s1_hs, s1_vs;
    logic [1:0]    s1_mode;

    always_comb begin
        vis_lines = oh + YW'(2 * MARGIN);
        line_last = (xo == ow + XW'(HFP + HTAIL - 1));
        act_row   = (yo >= YW'(MARGIN)) && (yo < oh + YW'(MARGIN));
        act_pix   = act_row && (xo < ow);
        hb_c      = (xo >= ow);
        hs_c      = (xo >= ow + XW'(HFP)) && (xo < ow + XW'(HFP + HSYNC_W));
        vb_c      = (yo >= vis_lines);
        vs_c      = (yo >= vis_lines + YW'(VSYNC_START))
                 && (yo < vis_lines + YW'(VSYNC_START + VSYNC_W));
        rd_phase  = PH_VBLANK;
        if (yo < YW'(MARGIN))  rd_phase = PH_TOP;
        else if (act_row)      rd_phase = PH_ACTIVE;
        else if (!vb_c)        rd_phase = PH_BOTTOM;
    end

    // yo saturates past the vsync lines so a missing swap leaves one vsync and a held vblank.
    always_ff @(posedge clk) begin
        if (reset) begin
            rseen      <= 1'b0;
            rmode      <= 2'd0;
            ow         <= XW'(WIDTH);
            oh         <= YW'(HEIGHT);
            xo         <= '0;
            yo         <= YW'(2 * MARGIN + HEIGHT);
            raddr      <= '0;
            s1_act     <= 1'b0;
            s1_hb      <= 1'b1;
            s1_vb      <= 1'b1;
            s1_hs      <= 1'b0;
            s1_vs      <= 1'b0;
            s1_mode    <= 2'd0;
            video_out  <= '0;
            hblank_out <= 1'b1;
            vblank_out <= 1'b1;
            hsync      <= 1'b0;
            vsync      <= 1'b0;
            mode_out   <= 2'd0;
        end else begin
            if (ce_out) begin
                s1_act  <= act_pix;
                s1_hb   <= hb_c;
                s1_vb   <= vb_c;
                s1_hs   <= hs_c;
                s1_vs   <= vs_c;
                s1_mode <= rmode;
                if (act_pix) raddr <= raddr + AW'(1);
                if (line_last) begin
                    xo <= '0;
                    if (wbuf != rseen) begin
                        rseen <= wbuf;
                        rmode <= bmode[!wbuf];
                        ow    <= is_rotated(bmode[!wbuf]) ? XW'(HEIGHT) : XW'(WIDTH);
                        oh    <= is_rotated(bmode[!wbuf]) ? YW'(WIDTH) : YW'(HEIGHT);
                        yo    <= '0;
                        raddr <= wbuf ? '0 : AW'(S);
                    end else if (yo < vis_lines + YW'(VSYNC_START + VSYNC_W)) begin
                        yo <= yo + YW'(1);
                    end
                end else begin
                    xo <= xo + XW'(1);
                end
            end
            video_out  <= s1_act ? s1_data : '0;
            hblank_out <= s1_hb;
            vblank_out <= s1_vb;
            hsync      <= s1_hs;
            vsync      <= s1_vs;
            mode_out   <= s1_mode;
        end
    end

endmodule
